// File: rtl/alu_modes.sv
// rtl/alu_modes.sv - shared alu mode encoding, legality check and arbiter FSM states
// Purpose: one place for the alu opcode map so the alu and its arbiter agree.
// Ports: none (package).
package alu_modes;

    // 4-bit opcode space; encodings 8..15 are unused and flagged as errors.
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_MUL = 4'd7
    } alu_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    function automatic logic is_legal_mode(input logic [3:0] mode);
        return (mode <= 4'd7);
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational WIDTH-bit alu
// Purpose: computes one operation per mode; illegal modes give zero result/carry and err=1.
// Ports:
//   a_i, b_i   in  WIDTH  operands
//   mode_i     in  4      alu_mode_e encoding
//   result_o   out WIDTH  result (low WIDTH bits for MUL)
//   carry_o    out 1      ADD carry-out / SUB borrow, else 0
//   err_o      out 1      mode is not a legal encoding
module alu
    import alu_modes::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       mode_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             err_o
);

    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] prod_w;
    logic [SH_W-1:0]  shamt_w;

    assign sum_w   = {1'b0, a_i} + {1'b0, b_i};
    // Top bit of the WIDTH+1 difference is the borrow.
    assign diff_w  = {1'b0, a_i} - {1'b0, b_i};
    assign prod_w  = a_i * b_i;
    assign shamt_w = b_i[SH_W-1:0];

    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        err_o    = !is_legal_mode(mode_i);
        case (mode_i)
            ALU_ADD: {carry_o, result_o} = sum_w;
            ALU_SUB: {carry_o, result_o} = diff_w;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_SLL: result_o = a_i << shamt_w;
            ALU_SRL: result_o = a_i >> shamt_w;
            ALU_MUL: result_o = prod_w;
            default: begin
                result_o = '0;
                carry_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - round-robin arbiter sharing one alu between NUM_REQ requesters
// Purpose: grants one requester at a time, registers its operands, runs the alu for one
//   cycle and presents a tagged response held until the consumer takes it.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-requester handshake; req_ready is a one-hot grant
//   req_a/req_b/req_mode packed per-requester operands and mode (slice i = requester i)
//   rsp_valid/rsp_ready response handshake
//   rsp_id/rsp_result/rsp_carry/rsp_err  response payload
//   busy                FSM not idle
//   op_count            saturating count of consumed responses
module alu_rr_arbiter
    import alu_modes::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ*4-1:0]       req_mode,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_result,
    output logic                       rsp_carry,
    output logic                       rsp_err,
    output logic                       busy,
    output logic [CNT_W-1:0]           op_count
);

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_e       state_q;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  rr_ptr_d;
    logic [ID_W-1:0]  id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       mode_q;
    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_carry_q;
    logic             rsp_err_q;
    logic             busy_q;
    logic [CNT_W-1:0] op_count_q;

    logic [ID_W-1:0]  grant_id;
    logic             grant_found;
    logic             can_accept;
    logic             accept;

    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_err;

    // (base + off) mod NUM_REQ without requiring NUM_REQ to be a power of two.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return ID_W'(s);
    endfunction

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_id    = '0;
        grant_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[wrap_add(rr_ptr_q, i)]) begin
                grant_id    = wrap_add(rr_ptr_q, i);
                grant_found = 1'b1;
            end
        end
    end

    // Grant is suppressed during reset so nothing is offered while the FSM is being cleared.
    assign can_accept = (state_q == IDLE) && !rst;
    assign accept     = can_accept && grant_found;
    assign req_ready  = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id) : '0;
    assign rr_ptr_d   = wrap_add(grant_id, 1);

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .mode_i   (mode_q),
        .result_o (alu_result),
        .carry_o  (alu_carry),
        .err_o    (alu_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            mode_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q      <= req_a[grant_id*WIDTH +: WIDTH];
                        b_q      <= req_b[grant_id*WIDTH +: WIDTH];
                        mode_q   <= req_mode[grant_id*4 +: 4];
                        id_q     <= grant_id;
                        rr_ptr_q <= rr_ptr_d;
                        busy_q   <= 1'b1;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result_q <= alu_result;
                    rsp_carry_q  <= alu_carry;
                    rsp_err_q    <= alu_err;
                    rsp_id_q     <= id_q;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        if (op_count_q != {CNT_W{1'b1}}) begin
                            op_count_q <= op_count_q + CNT_W'(1);
                        end
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb/tb_alu_rr_arbiter.sv - directed self-checking bench for alu_rr_arbiter
module tb_alu_rr_arbiter;
    import alu_modes::*;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int CW = 3;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic [N*4-1:0]  req_mode;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [W-1:0]    rsp_result;
    logic            rsp_carry;
    logic            rsp_err;
    logic            busy;
    logic [CW-1:0]   op_count;

    int errors  = 0;
    int checks  = 0;
    int exp_cnt = 0;
    int g;

    always #5 clk = ~clk;

    alu_rr_arbiter #(
        .WIDTH   (W),
        .NUM_REQ (N),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_mode   (req_mode),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .op_count   (op_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
        req_mode[r*4 +: 4] = m;
        req_a[r*W +: W]    = a;
        req_b[r*W +: W]    = b;
    endtask

    task automatic bump_cnt();
        if (exp_cnt < (1 << CW) - 1) exp_cnt++;
    endtask

    // Samples at negedges until a grant shows; bounded.
    task automatic wait_grant(output int id);
        id = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) id = i;
                break;
            end
        end
        check("grant_seen", (id >= 0), 1);
        check("grant_onehot", $countones(req_ready), 1);
    endtask

    task automatic check_rsp(input int id, input logic [31:0] res, input logic c, input logic e);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, id);
        check("rsp_result", rsp_result, res);
        check("rsp_carry", rsp_carry, c);
        check("rsp_err", rsp_err, e);
    endtask

    // One isolated op from requester r; entered and left just after a posedge.
    task automatic run_op(input int r, input logic [3:0] m, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic c, input logic e);
        int gid;
        req_valid    = '0;
        set_req(r, m, a, b);
        req_valid[r] = 1'b1;
        rsp_ready    = 1'b1;
        wait_grant(gid);
        check("grant_id", gid, r);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("exec_rsp_valid", rsp_valid, 0);
        check("exec_busy", busy, 1);
        @(negedge clk);
        check_rsp(r, res, c, e);
        @(posedge clk); #1;
        bump_cnt();
        @(negedge clk);
        check("done_rsp_valid", rsp_valid, 0);
        check("op_count", op_count, exp_cnt);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // 1: reset with every requester valid
        rst       = 1'b1;
        rsp_ready = 1'b0;
        req_valid = '1;
        for (int i = 0; i < N; i++) set_req(i, ALU_ADD, 32'd1, 32'd2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_op_count", op_count, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_result", rsp_result, 0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = '0;

        // 2: ADD overflow from requester 0
        run_op(0, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);

        // 3: all requesters valid, fresh pointer: grants 0,1,2,3,0
        rst = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < N; i++) set_req(i, ALU_SUB, 32'd5, 32'd7);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g);
            check("rr_grant", g, k % N);
            @(negedge clk);
            check("rr_exec_valid", rsp_valid, 0);
            @(negedge clk);
            check_rsp(k % N, 32'hFFFF_FFFE, 1'b1, 1'b0);
            bump_cnt();
        end

        // 4: response back-pressure; rr_ptr is now 1
        wait_grant(g);
        check("bp_grant", g, 1);
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_rsp(1, 32'hFFFF_FFFE, 1'b1, 1'b0);
        repeat (4) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_id", rsp_id, 1);
            check("bp_result", rsp_result, 32'hFFFF_FFFE);
            check("bp_carry", rsp_carry, 1);
            check("bp_req_ready", req_ready, 0);
            check("bp_busy", busy, 1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        bump_cnt();
        check("bp_released", rsp_valid, 0);
        check("bp_next_grant", req_ready, 4'b0100);
        check("bp_op_count", op_count, exp_cnt);
        req_valid = '0;
        @(posedge clk); #1;

        // 5: illegal mode, then legal ops incl. shift-amount masking and MUL truncation
        run_op(2, 4'hF, 32'h0000_0123, 32'h0000_0456, 32'd0, 1'b0, 1'b1);
        run_op(3, ALU_MUL, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 1'b0, 1'b0);
        run_op(0, ALU_SLL, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
        run_op(1, ALU_SRL, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 1'b0, 1'b0);
        run_op(2, ALU_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1'b0);

        // 6: reset while requester 1 is in EXEC
        req_valid    = '0;
        set_req(1, ALU_ADD, 32'd2, 32'd3);
        req_valid[1] = 1'b1;
        rsp_ready    = 1'b1;
        wait_grant(g);
        check("rx_grant", g, 1);
        @(posedge clk); #1;
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        rst     = 1'b0;
        exp_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            check("rx_no_rsp", rsp_valid, 0);
            check("rx_busy", busy, 0);
        end
        check("rx_op_count", op_count, 0);
        @(posedge clk); #1;
        set_req(3, ALU_SUB, 32'd10, 32'd3);
        req_valid = 4'b1010;
        wait_grant(g);
        check("rx_first", g, 1);
        @(posedge clk); #1;
        req_valid = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        check_rsp(1, 32'd5, 1'b0, 1'b0);
        wait_grant(g);
        check("rx_second", g, 3);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check_rsp(3, 32'd7, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
